// File: rtl/bus_scheduler.sv
`default_nettype none
// ============================================================================
// bus_scheduler : time-sliced FCFS arbiter sharing the system bus among IDs 1..7
// Rev 1.0
// ============================================================================
module bus_scheduler #(
  parameter int unsigned QUANTUM = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:1] req,
  output logic [7:1] grt,
  output logic [2:0] owner,
  output logic       busy,
  output logic       preempt,
  output logic [2:0] qcount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] QRELOAD = 4'(QUANTUM - 1);

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [7:1] grt_q, grt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       preempt_q, preempt_d;
  logic [2:0] count_q, count_d;
  logic [2:0] queue_q [7];
  logic [2:0] queue_d [7];

  logic [7:0] req_ext;
  logic [2:0] kept [7];
  logic [3:0] kept_n;
  logic [2:0] shifted [7];
  logic [3:0] new_n;
  logic       is_q;
  logic       do_grant;
  logic       do_preempt;

  assign req_ext = {req, 1'b0};

  // Drop every queued ID whose request has fallen, keeping arrival order.
  always_comb begin
    kept   = '{default: 3'd0};
    kept_n = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) < count_q && req_ext[queue_q[i]]) begin
        kept[kept_n[2:0]] = queue_q[i];
        kept_n            = kept_n + 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    preempt_d  = 1'b0;
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    case (state_q)
      ST_GRANT: begin
        if (!req_ext[owner_q]) begin
          owner_d = 3'd0;
          state_d = ST_GAP;
        end else if (cnt_q == 4'd0) begin
          if (kept_n != 4'd0) begin
            do_preempt = 1'b1;
            preempt_d  = 1'b1;
            owner_d    = 3'd0;
            state_d    = ST_GAP;
          end else begin
            cnt_d = QRELOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // IDLE and GAP both hand the bus to the head of the queue
        if (kept_n != 4'd0) begin
          do_grant = 1'b1;
          owner_d  = kept[0];
          cnt_d    = QRELOAD;
          state_d  = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    grt_d = '0;
    for (int i = 1; i < 8; i++) begin
      if (owner_d == 3'(i)) grt_d[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      shifted[i] = do_grant ? kept[i+1] : kept[i];
    end
    shifted[6] = do_grant ? 3'd0 : kept[6];
    new_n      = kept_n - {3'd0, do_grant};
    queue_d    = shifted;
    if (do_preempt && new_n < 4'd7) begin
      queue_d[new_n[2:0]] = owner_q;
      new_n               = new_n + 4'd1;
    end
    // New arrivals join the tail in ascending ID order.
    for (int id = 1; id < 8; id++) begin
      is_q = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (3'(i) < count_q && queue_q[i] == 3'(id)) is_q = 1'b1;
      end
      if (req_ext[id] && !is_q && owner_q != 3'(id) && new_n < 4'd7) begin
        queue_d[new_n[2:0]] = 3'(id);
        new_n               = new_n + 4'd1;
      end
    end
    count_d = new_n[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 3'd0;
      grt_q     <= '0;
      cnt_q     <= 4'd0;
      preempt_q <= 1'b0;
      count_q   <= 3'd0;
      for (int i = 0; i < 7; i++) queue_q[i] <= 3'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grt_q     <= grt_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
      count_q   <= count_d;
      queue_q   <= queue_d;
    end
  end

  assign grt     = grt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ST_GRANT);
  assign preempt = preempt_q;
  assign qcount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_scheduler.sv
`default_nettype none
// ============================================================================
// tb_bus_scheduler : scoreboard bench for bus_scheduler (QUANTUM = 8)
// Rev 1.0
// ============================================================================
module tb_bus_scheduler;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n   = 1'b1;
  logic [7:1] req     = '0;
  logic [7:1] grt;
  logic [2:0] owner;
  logic       busy;
  logic       preempt;
  logic [2:0] qcount;

  int         checks   = 0;
  int         failures = 0;
  int         exp_q[$];
  int         exp_id;
  logic [7:1] prev_grt = '0;

  bus_scheduler #(.QUANTUM(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grt     (grt),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt),
    .qcount  (qcount)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:1] onehot(input int id);
    logic [7:1] v;
    v = '0;
    if (id >= 1 && id <= 7) v[id] = 1'b1;
    return v;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every new grant must match the next ID the stimulus expects.
  always @(negedge clk) begin
    if (rst_n) begin
      check("grt_vs_owner", grt, onehot(owner));
      check("busy_vs_grt", busy, grt != '0);
      if (preempt) check("preempt_gap_grt", grt, 7'd0);
      if (prev_grt != '0 && grt != '0) check("grt_stable", grt, prev_grt);
      if (prev_grt == '0 && grt != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", owner, 3'd0);
        end else begin
          exp_id = exp_q.pop_front();
          check("grant_order", owner, exp_id);
        end
      end
      prev_grt = grt;
    end
  end

  initial begin
    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    #1;
    check("rst_grt", grt, 7'd0);
    check("rst_owner", owner, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_preempt", preempt, 1'b0);
    check("rst_qcount", qcount, 3'd0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_grt", grt, 7'd0);
      check("idle_qcount", qcount, 3'd0);
    end

    // ---------------- single requester ----------------
    req[2] = 1'b1;
    exp_q.push_back(2);
    tick();
    check("single_enq_qcount", qcount, 3'd1);
    check("single_enq_grt", grt, 7'd0);
    tick();
    check("single_grt", grt, 7'b0000010);
    check("single_owner", owner, 3'd2);
    check("single_busy", busy, 1'b1);
    check("single_qcount", qcount, 3'd0);
    tick(3);
    req[2] = 1'b0;
    check("single_hold_after_drop", grt, 7'b0000010);
    tick();
    check("single_release_grt", grt, 7'd0);
    check("single_release_busy", busy, 1'b0);
    tick();
    check("single_idle_busy", busy, 1'b0);

    // ---------------- FCFS order ----------------
    req[5] = 1'b1;
    exp_q.push_back(5);
    tick(2);
    check("fcfs_owner5", owner, 3'd5);
    req[3] = 1'b1;
    exp_q.push_back(3);
    tick();
    check("fcfs_qcount1", qcount, 3'd1);
    tick();
    req[6] = 1'b1;
    exp_q.push_back(6);
    tick();
    check("fcfs_qcount2", qcount, 3'd2);
    req[5] = 1'b0;
    tick();
    check("fcfs_gap1", grt, 7'd0);
    check("fcfs_gap1_qcount", qcount, 3'd2);
    tick();
    check("fcfs_owner3", owner, 3'd3);
    check("fcfs_q_after3", qcount, 3'd1);
    tick();
    req[3] = 1'b0;
    tick();
    check("fcfs_gap2", grt, 7'd0);
    tick();
    check("fcfs_owner6", owner, 3'd6);
    tick();
    req[6] = 1'b0;
    tick(2);
    check("fcfs_idle_busy", busy, 1'b0);

    // ---------------- preemption, 3 rounds each ----------------
    req[2] = 1'b1;
    tick();
    req[4] = 1'b1;
    tick();
    for (int n = 0; n < 7; n++) exp_q.push_back((n % 2 == 0) ? 2 : 4);
    for (int r = 0; r < 6; r++) begin
      int id;
      id = (r % 2 == 0) ? 2 : 4;
      for (int c = 0; c < 8; c++) begin
        check("pre_hold_grt", grt, onehot(id));
        check("pre_hold_preempt", preempt, 1'b0);
        tick();
      end
      check("pre_pulse", preempt, 1'b1);
      check("pre_gap_grt", grt, 7'd0);
      check("pre_gap_qcount", qcount, 3'd2);
      tick();
      check("pre_pulse_end", preempt, 1'b0);
    end
    check("pre_final_grt", grt, onehot(2));
    req = '0;
    tick();
    check("pre_rel_grt", grt, 7'd0);
    check("pre_rel_preempt", preempt, 1'b0);
    check("pre_rel_qcount", qcount, 3'd0);
    tick();

    // ---------------- queued withdrawal ----------------
    req[5] = 1'b1;
    exp_q.push_back(5);
    tick(2);
    req[3] = 1'b1;
    tick();
    req[6] = 1'b1;
    tick();
    req[1] = 1'b1;
    tick();
    check("wd_qcount3", qcount, 3'd3);
    exp_q.push_back(3);
    exp_q.push_back(1);
    req[6] = 1'b0;
    tick();
    check("wd_qcount2", qcount, 3'd2);
    req[5] = 1'b0;
    tick();
    check("wd_gap_grt", grt, 7'd0);
    tick();
    check("wd_owner3", owner, 3'd3);
    req[3] = 1'b0;
    tick(2);
    check("wd_owner1", owner, 3'd1);
    req[1] = 1'b0;
    tick(2);
    check("wd_idle_qcount", qcount, 3'd0);

    // ---------------- simultaneous arrivals ----------------
    req[7] = 1'b1;
    req[1] = 1'b1;
    req[4] = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(7);
    tick();
    check("sim_qcount3", qcount, 3'd3);
    tick();
    check("sim_owner1", owner, 3'd1);
    req[1] = 1'b0;
    tick(2);
    check("sim_owner4", owner, 3'd4);
    req[4] = 1'b0;
    tick(2);
    check("sim_owner7", owner, 3'd7);
    req[7] = 1'b0;
    tick(2);

    // ---------------- quantum expiry with empty queue ----------------
    req[1] = 1'b1;
    exp_q.push_back(1);
    tick(2);
    for (int i = 0; i < 20; i++) begin
      check("solo_grt", grt, 7'b0000001);
      check("solo_preempt", preempt, 1'b0);
      tick();
    end
    req[3] = 1'b1;
    tick();
    check("solo_qcount", qcount, 3'd1);

    // ---------------- asynchronous reset with clock stopped ----------------
    @(negedge clk);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_grt", grt, 7'd0);
    check("arst_owner", owner, 3'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_qcount", qcount, 3'd0);
    check("arst_preempt", preempt, 1'b0);
    req = '0;
    #10 rst_n = 1'b1;
    #1 clk_run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_grt", grt, 7'd0);
      check("post_rst_qcount", qcount, 3'd0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_scheduler.md
# bus_scheduler

Time-sliced, first-come-first-served scheduler that shares the MiniComputer system bus among seven requesters (IDs 1..7; ID 0 means "no owner"). It keeps an arrival-ordered queue of pending requester IDs and grants the bus one-hot to the head. It releases the grant when the owner drops its request, and preempts the owner after a fixed quantum if others are waiting. It sits between the requesting units and the bus multiplexer, and also drives the bus-select ID.

## Interface
- QUANTUM, 8, grant cycles before preemption is considered; legal range 1..16, 4-bit counter.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset; asynchronous, active-low; clears all state immediately.
- req  in  [7:1]  level requests; req[i] held high while requester i wants or uses the bus.
- grt  out  [7:1]  one-hot grant, registered; all zero when no owner.
- owner  out  [2:0]  ID of current owner, 0 when none; registered.
- busy  out  1  high while in GRANT.
- preempt  out  1  one-cycle pulse, high during the GAP cycle that follows a preemption.
- qcount  out  [2:0]  number of queued IDs (0..7), excluding the owner.

## Operation
- Queue: 7 entries of 3-bit IDs, head at entry 0; each ID appears at most once and is never simultaneously owner and queued, so there is no overflow.
- Per-edge queue update, in this order:
  1. Remove every queued ID whose req is low; entries behind shift toward the head, preserving order.
  2. If a grant is issued this edge, pop the head.
  3. If a preemption occurs this edge, append the preempted owner.
  4. Append arrivals in ascending index order. An arrival is an ID i with req[i]=1, i not queued, and i not owner.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If the post-removal queue is non-empty, pop the head, set grt/owner, load the counter with QUANTUM-1, and go to GRANT.
  - Otherwise stay in IDLE; arrivals are still enqueued.
- GRANT:
  - If req[owner]=0: clear grt/owner and go to GAP.
  - Else if counter=0 and the post-removal queue is non-empty: preempt. Clear grt/owner, append owner, set preempt=1, go to GAP.
  - Else if counter=0 and the queue is empty: reload QUANTUM-1 and keep the grant.
  - Otherwise decrement the counter.
- GAP: exactly one cycle with grt=0. At the next edge, if the post-removal queue is non-empty, pop the head and go to GRANT (same actions as IDLE); otherwise go to IDLE.
- Derived outputs: busy=1 iff state=GRANT; preempt=1 iff GAP was entered by preemption.

## Timing
- Reset (Rst=0, no clock needed): grt=0, owner=0, busy=0, preempt=0, qcount=0, queue empty, state IDLE, counter 0.
- On reset release, requests already high count as arrivals at the first edge, in ascending order.
- Latency from idle: req[i] rises before edge E0, i is enqueued at E0, and grt[i] goes high after E1 (2 edges).
- Release: req[owner] low before edge E causes grt to clear after E. grt therefore stays high one cycle after req falls.
- Turnaround: minimum 1 cycle of grt=0 between any two grants, including preemption and same-ID re-grant.
- Quantum: without a release, a granted owner holds grt for exactly QUANTUM cycles before preemption. QUANTUM=1 means the owner is preempted after 1 cycle whenever the queue is non-empty.
- A queued ID that drops and re-raises req loses its place and re-enters at the tail.
- An owner that releases and re-raises during GAP re-enters at the tail after the existing queue.
- Simultaneous release and quantum expiry: release wins; there is no preempt pulse and the owner is not re-queued.
- Mid-operation reset: grt clears asynchronously and all queue contents are discarded.

## Test plan
- Reset: assert Rst=0 mid-GRANT with the clock stopped → grt=0, owner=0, busy=0, qcount=0 immediately. Release with req=0 → outputs stay 0 for 10 cycles.
- Single requester: raise req[2] → grt=7'b0000010, owner=2 two edges later. Drop req[2] → grt=0 one edge later, busy low, then IDLE.
- FCFS order: req[5] raised; while 5 owns, raise req[3], then req[6] two cycles later. Grant order must be 5, 3, 6, each separated by one zero cycle; qcount peaks at 2.
- Preemption, QUANTUM=8: hold req[2] and req[4] (2 first) → grt[2] high 8 cycles, preempt pulse 1 cycle with grt=0, grt[4] high 8 cycles, then grt[2] again. Repeat for 3 rounds.
- Queued withdrawal: owner 5 with queue [3,6,1], qcount=3; drop req[6] → qcount=2 next edge; after 5 releases the order is 3 then 1.
- Simultaneous arrivals: req[7], req[1], req[4] raised in the same cycle from IDLE → grants in order 1, 4, 7. With req[1] held at quantum expiry and the queue empty → no preempt and grt[1] stays high continuously.
